// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared types and constants for the 5-stage RV32 hazard controller.
//   - fwd_sel_e      : EX operand source encoding (register file / MEM / WB)
//   - SB_* indices   : scoreboard entry positions (EX is the youngest entry)
//   - ctrl_cause_e   : which rule currently owns the pipeline controls
//   - hz_ctrl_t      : bundle of stall/bubble/flush controls
//   - fwd_pick()     : forward-source selection from per-entry matches
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  localparam int SB_DEPTH = 3;
  localparam int SB_EX    = 0;
  localparam int SB_MEM   = 1;
  localparam int SB_WB    = 2;

  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_RESET    = 3'd1,
    CAUSE_REDIRECT = 3'd2,
    CAUSE_HAZARD   = 3'd3,
    CAUSE_JUMP     = 3'd4
  } ctrl_cause_e;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic bubble_ex;
    logic flush_if;
  } hz_ctrl_t;

  // The producer one stage ahead (now in EX) is the youngest, so it wins over
  // an older producer of the same register sitting in MEM.
  function automatic fwd_sel_e fwd_pick(input logic ex_match, input logic mem_match);
    fwd_sel_e sel;
    if (ex_match) begin
      sel = FWD_MEM;
    end else if (mem_match) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Three-entry shift register of in-flight destination registers
// (EX -> MEM -> WB) and per-entry source-match vectors.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   push_vld/push_rd/
//   push_is_load             instruction issuing into EX this cycle (writes rd)
//   rs1/rs1_vld, rs2/rs2_vld source operands of the instruction in ID
//   rs1_match, rs2_match     bit i set when entry i produces that source
//   ent_is_load              bit i set when entry i is a load
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_vld,
  input  logic [REG_AW-1:0]   push_rd,
  input  logic                push_is_load,
  input  logic [REG_AW-1:0]   rs1,
  input  logic                rs1_vld,
  input  logic [REG_AW-1:0]   rs2,
  input  logic                rs2_vld,
  output logic [SB_DEPTH-1:0] rs1_match,
  output logic [SB_DEPTH-1:0] rs2_match,
  output logic [SB_DEPTH-1:0] ent_is_load
);

  logic [SB_DEPTH-1:0] vld_r;
  logic [SB_DEPTH-1:0] ld_r;
  logic [REG_AW-1:0]   rd_r [SB_DEPTH];

  // Advance every entry one stage per cycle; a non-issuing cycle inserts an empty entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= {SB_DEPTH{1'b0}};
      ld_r  <= {SB_DEPTH{1'b0}};
      for (int i = 0; i < SB_DEPTH; i++) begin
        rd_r[i] <= {REG_AW{1'b0}};
      end
    end else begin
      vld_r   <= {vld_r[SB_DEPTH-2:0], push_vld};
      ld_r    <= {ld_r[SB_DEPTH-2:0], push_vld & push_is_load};
      rd_r[0] <= push_rd;
      for (int i = 1; i < SB_DEPTH; i++) begin
        rd_r[i] <= rd_r[i-1];
      end
    end
  end

  // Per-entry source matching; x0 is hardwired to zero and never matches.
  always_comb begin
    rs1_match = {SB_DEPTH{1'b0}};
    rs2_match = {SB_DEPTH{1'b0}};
    for (int i = 0; i < SB_DEPTH; i++) begin
      rs1_match[i] = rs1_vld && (rs1 != {REG_AW{1'b0}}) && vld_r[i] && (rd_r[i] == rs1);
      rs2_match[i] = rs2_vld && (rs2 != {REG_AW{1'b0}}) && vld_r[i] && (rd_r[i] == rs2);
    end
  end

  assign ent_is_load = ld_r;

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Hazard controller for the 5-stage RV32 core. Generates stall/bubble/flush
// controls for the IF/ID and ID/EX registers, registered EX forward selects
// and a stall-cycle performance counter.
//
// Build option: define FORWARD_EN to enable operand forwarding (only load-use
// stalls). Without it every RAW on an EX/MEM producer stalls and the forward
// selects are constant 0.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   id_vld                      ID holds a valid instruction
//   id_rs1/id_rs2(+_vld)        source registers and their use flags
//   id_rd/id_rd_vld             destination register and write flag
//   id_is_load                  ID instruction is a load
//   id_jmp_vld                  JAL decoded in ID
//   ex_redirect                 taken branch / JALR resolved in EX
//   stall_if, stall_id          hold PC + IF/ID, hold ID
//   bubble_ex                   insert NOP into ID/EX
//   flush_if                    invalidate IF/ID
//   fwd_rs1_sel, fwd_rs2_sel    EX operand source (0 = RF, 1 = MEM, 2 = WB)
//   stall_cnt                   cycles spent stalled on a hazard
// -----------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_vld,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_vld,
  input  logic              id_rs2_vld,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_vld,
  input  logic              id_is_load,
  input  logic              id_jmp_vld,
  input  logic              ex_redirect,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              flush_if,
  output logic [1:0]        fwd_rs1_sel,
  output logic [1:0]        fwd_rs2_sel,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [SB_DEPTH-1:0] rs1_match_s;
  logic [SB_DEPTH-1:0] rs2_match_s;
  logic [SB_DEPTH-1:0] ent_is_load_s;
  logic                hazard_s;
  logic                issue_s;
  logic                push_vld_s;
  ctrl_cause_e         cause_s;
  hz_ctrl_t            ctrl_s;
  logic [CNT_W-1:0]    stall_cnt_r;
  logic                sb_unused_s;

  hazard_scoreboard #(
    .REG_AW (REG_AW)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .push_vld     (push_vld_s),
    .push_rd      (id_rd),
    .push_is_load (id_is_load),
    .rs1          (id_rs1),
    .rs1_vld      (id_rs1_vld),
    .rs2          (id_rs2),
    .rs2_vld      (id_rs2_vld),
    .rs1_match    (rs1_match_s),
    .rs2_match    (rs2_match_s),
    .ent_is_load  (ent_is_load_s)
  );

  // The WB entry never causes a hazard (write-before-read regfile); some
  // entry flags are only consumed in the forwarding build.
  assign sb_unused_s = ^{rs1_match_s[SB_WB], rs2_match_s[SB_WB], ent_is_load_s};

  // RAW hazard detection; an invalid ID slot carries no real sources.
  always_comb begin
    hazard_s = 1'b0;
    if (id_vld) begin
`ifdef FORWARD_EN
      hazard_s = (rs1_match_s[SB_EX] | rs2_match_s[SB_EX]) & ent_is_load_s[SB_EX];
`else
      hazard_s = rs1_match_s[SB_EX] | rs1_match_s[SB_MEM] |
                 rs2_match_s[SB_EX] | rs2_match_s[SB_MEM];
`endif
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign issue_s    = id_vld & ~hazard_s & ~ex_redirect;
  assign push_vld_s = issue_s & id_rd_vld & (id_rd != {REG_AW{1'b0}});

  // Pick the highest-priority rule owning the controls this cycle.
  always_comb begin
    cause_s = CAUSE_NONE;
    if (rst) begin
      cause_s = CAUSE_RESET;
    end else if (ex_redirect) begin
      // ID holds a wrong-path instruction, so its hazard is irrelevant.
      cause_s = CAUSE_REDIRECT;
    end else if (hazard_s) begin
      cause_s = CAUSE_HAZARD;
    end else if (id_vld & id_jmp_vld) begin
      cause_s = CAUSE_JUMP;
    end else begin
      cause_s = CAUSE_NONE;
    end
  end

  // Decode the owning rule into the control bundle.
  always_comb begin
    ctrl_s = '{stall_if: 1'b0, stall_id: 1'b0, bubble_ex: 1'b0, flush_if: 1'b0};
    case (cause_s)
      CAUSE_RESET, CAUSE_REDIRECT: begin
        ctrl_s.flush_if  = 1'b1;
        ctrl_s.bubble_ex = 1'b1;
      end
      CAUSE_HAZARD: begin
        ctrl_s.stall_if  = 1'b1;
        ctrl_s.stall_id  = 1'b1;
        ctrl_s.bubble_ex = 1'b1;
      end
      CAUSE_JUMP: begin
        ctrl_s.flush_if = 1'b1;
      end
      CAUSE_NONE: begin
        ctrl_s = '{stall_if: 1'b0, stall_id: 1'b0, bubble_ex: 1'b0, flush_if: 1'b0};
      end
      default: begin
        ctrl_s = '{stall_if: 1'b0, stall_id: 1'b0, bubble_ex: 1'b1, flush_if: 1'b1};
      end
    endcase
  end

  assign stall_if  = ctrl_s.stall_if;
  assign stall_id  = ctrl_s.stall_id;
  assign bubble_ex = ctrl_s.bubble_ex;
  assign flush_if  = ctrl_s.flush_if;

  // Count hazard-stall cycles; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (ctrl_s.stall_id) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;

`ifdef FORWARD_EN
  logic [1:0] fwd_rs1_r;
  logic [1:0] fwd_rs2_r;

  // Forward selects travel with the instruction into EX; anything that is
  // not an issuing instruction (bubble or empty slot) reads the regfile.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_rs1_r <= FWD_RF;
      fwd_rs2_r <= FWD_RF;
    end else if (issue_s) begin
      fwd_rs1_r <= fwd_pick(rs1_match_s[SB_EX], rs1_match_s[SB_MEM]);
      fwd_rs2_r <= fwd_pick(rs2_match_s[SB_EX], rs2_match_s[SB_MEM]);
    end else begin
      fwd_rs1_r <= FWD_RF;
      fwd_rs2_r <= FWD_RF;
    end
  end

  assign fwd_rs1_sel = fwd_rs1_r;
  assign fwd_rs2_sel = fwd_rs2_r;
`else
  assign fwd_rs1_sel = 2'd0;
  assign fwd_rs2_sel = 2'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed bench for pipeline_ctrl. A reference model keeps a per-cycle log of
// issued register writes and derives hazards from producer distance (cycles
// since issue); a compare process checks every output on every falling edge.
// Directed tests add hand-computed literal expectations. Works for both builds
// (FORWARD_EN defined or not).
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;
  localparam int LOG_N  = 4096;
`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              id_vld = 1'b0;
  logic [REG_AW-1:0] id_rs1 = 5'd0;
  logic [REG_AW-1:0] id_rs2 = 5'd0;
  logic              id_rs1_vld = 1'b0;
  logic              id_rs2_vld = 1'b0;
  logic [REG_AW-1:0] id_rd = 5'd0;
  logic              id_rd_vld = 1'b0;
  logic              id_is_load = 1'b0;
  logic              id_jmp_vld = 1'b0;
  logic              ex_redirect = 1'b0;
  logic              stall_if;
  logic              stall_id;
  logic              bubble_ex;
  logic              flush_if;
  logic [1:0]        fwd_rs1_sel;
  logic [1:0]        fwd_rs2_sel;
  logic [CNT_W-1:0]  stall_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .REG_AW (REG_AW),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_vld      (id_vld),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_vld  (id_rs1_vld),
    .id_rs2_vld  (id_rs2_vld),
    .id_rd       (id_rd),
    .id_rd_vld   (id_rd_vld),
    .id_is_load  (id_is_load),
    .id_jmp_vld  (id_jmp_vld),
    .ex_redirect (ex_redirect),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .bubble_ex   (bubble_ex),
    .flush_if    (flush_if),
    .fwd_rs1_sel (fwd_rs1_sel),
    .fwd_rs2_sel (fwd_rs2_sel),
    .stall_cnt   (stall_cnt)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // log_*[c] records the register write issued at the edge ending cycle c.
  int          cyc      = 0;
  int          rst_mark = -1;
  bit          log_wr [LOG_N];
  logic [4:0]  log_rd [LOG_N];
  bit          log_ld [LOG_N];
  logic [1:0]  exp_f1_r  = 2'd0;
  logic [1:0]  exp_f2_r  = 2'd0;
  logic [31:0] exp_cnt_r = 32'd0;

  typedef struct packed {
    logic       stall;
    logic       bubble;
    logic       flush;
    logic       issue;
    logic       push;
    logic [1:0] f1;
    logic [1:0] f2;
  } exp_t;

  exp_t exp_c;

  // Distance (1 = issued last cycle, 2 = two cycles ago) of the youngest
  // in-flight producer of rs that can still hazard; 0 if none.
  function automatic void producer(input logic [4:0] rs, input logic rsv,
                                   output int age, output logic ld);
    age = 0;
    ld  = 1'b0;
    for (int a = 2; a >= 1; a--) begin
      int idx;
      idx = cyc - a;
      if (rsv && rs != 5'd0 && idx > rst_mark && idx >= 0 && idx < LOG_N) begin
        if (log_wr[idx] && log_rd[idx] == rs) begin
          age = a;
          ld  = log_ld[idx];
        end
      end
    end
  endfunction

  function automatic exp_t model();
    exp_t e;
    int   a1, a2;
    logic l1, l2, haz;
    producer(id_rs1, id_rs1_vld, a1, l1);
    producer(id_rs2, id_rs2_vld, a2, l2);
    if (FWD) haz = id_vld && ((a1 == 1 && l1) || (a2 == 1 && l2));
    else     haz = id_vld && (a1 != 0 || a2 != 0);
    e = '0;
    if (rst) begin
      e.flush = 1'b1; e.bubble = 1'b1;
    end else if (ex_redirect) begin
      e.flush = 1'b1; e.bubble = 1'b1;
    end else if (haz) begin
      e.stall = 1'b1; e.bubble = 1'b1;
    end else if (id_vld && id_jmp_vld) begin
      e.flush = 1'b1;
    end
    e.issue = !rst && id_vld && !haz && !ex_redirect;
    e.push  = e.issue && id_rd_vld && id_rd != 5'd0;
    if (e.issue && FWD) begin
      e.f1 = (a1 == 1) ? 2'd1 : (a1 == 2) ? 2'd2 : 2'd0;
      e.f2 = (a2 == 1) ? 2'd1 : (a2 == 2) ? 2'd2 : 2'd0;
    end
    return e;
  endfunction

  always_comb exp_c = model();

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      rst_mark  <= cyc;
      exp_cnt_r <= 32'd0;
      exp_f1_r  <= 2'd0;
      exp_f2_r  <= 2'd0;
    end else begin
      if (cyc < LOG_N) begin
        log_wr[cyc] <= exp_c.push;
        log_rd[cyc] <= id_rd;
        log_ld[cyc] <= id_is_load;
      end
      if (exp_c.stall) exp_cnt_r <= exp_cnt_r + 32'd1;
      exp_f1_r <= exp_c.f1;
      exp_f2_r <= exp_c.f2;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("stall_if",    {31'd0, stall_if},    {31'd0, exp_c.stall});
    check("stall_id",    {31'd0, stall_id},    {31'd0, exp_c.stall});
    check("bubble_ex",   {31'd0, bubble_ex},   {31'd0, exp_c.bubble});
    check("flush_if",    {31'd0, flush_if},    {31'd0, exp_c.flush});
    check("fwd_rs1_sel", {30'd0, fwd_rs1_sel}, {30'd0, exp_f1_r});
    check("fwd_rs2_sel", {30'd0, fwd_rs2_sel}, {30'd0, exp_f2_r});
    check("stall_cnt",   stall_cnt,            exp_cnt_r);
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    id_vld = 1'b0; id_rs1 = 5'd0; id_rs1_vld = 1'b0; id_rs2 = 5'd0; id_rs2_vld = 1'b0;
    id_rd = 5'd0; id_rd_vld = 1'b0; id_is_load = 1'b0; id_jmp_vld = 1'b0; ex_redirect = 1'b0;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic rs1v, input logic [4:0] rs2,
                        input logic rs2v, input logic [4:0] rd, input logic rdv,
                        input logic ld, input logic jmp);
    id_vld = 1'b1; id_rs1 = rs1; id_rs1_vld = rs1v; id_rs2 = rs2; id_rs2_vld = rs2v;
    id_rd = rd; id_rd_vld = rdv; id_is_load = ld; id_jmp_vld = jmp; ex_redirect = 1'b0;
  endtask

  // Hold the ID instruction until it issues; returns stall cycles seen.
  task automatic wait_issue(output int nst);
    nst = 0;
    @(negedge clk);
    while (stall_id === 1'b1 && nst < 8) begin
      nst++;
      @(negedge clk);
    end
    if (nst >= 8) begin
      n_chk++;
      $display("FAIL issue_timeout: stalled %0d cycles, expected issue within 8", nst);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 50000");
    $fatal(1);
  end

  initial begin
    int nst;
    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_flush",  {31'd0, flush_if},  32'd1);
    check("rst_bubble", {31'd0, bubble_ex}, 32'd1);
    check("rst_stall",  {31'd0, stall_id},  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_cnt", stall_cnt, 32'd0);
    check("rst_fwd", {30'd0, fwd_rs1_sel}, 32'd0);

    // LW x5 ; ADD x6,x5,x7
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0); wait_issue(nst);
    set_id(5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); wait_issue(nst);
    check("lu_stalls", nst, FWD ? 32'd1 : 32'd2);
    check("lu_fwd1", {30'd0, fwd_rs1_sel}, FWD ? 32'd2 : 32'd0);
    check("lu_cnt", stall_cnt, FWD ? 32'd1 : 32'd2);

    // ADDI x5,x0 ; ADD x6,x5,x5
    set_id(5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0); wait_issue(nst);
    set_id(5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); wait_issue(nst);
    check("b2b_stalls", nst, FWD ? 32'd0 : 32'd2);
    check("b2b_fwd1", {30'd0, fwd_rs1_sel}, FWD ? 32'd1 : 32'd0);
    check("b2b_fwd2", {30'd0, fwd_rs2_sel}, FWD ? 32'd1 : 32'd0);
    check("b2b_cnt", stall_cnt, FWD ? 32'd1 : 32'd4);

    // ADDI x0,x0,1 ; ADD x1,x0,x0
    set_id(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); wait_issue(nst);
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0); wait_issue(nst);
    check("x0_stalls", nst, 32'd0);
    check("x0_fwd1", {30'd0, fwd_rs1_sel}, 32'd0);

    // ADDI x7 ; ADDI x8 ; ADD x9,x7,x0  (distance 2)
    set_id(5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0); wait_issue(nst);
    set_id(5'd0, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0); wait_issue(nst);
    set_id(5'd7, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0); wait_issue(nst);
    check("d2_stalls", nst, FWD ? 32'd0 : 32'd1);
    check("d2_fwd1", {30'd0, fwd_rs1_sel}, FWD ? 32'd2 : 32'd0);
    check("d2_cnt", stall_cnt, FWD ? 32'd1 : 32'd5);

    // ADDI x10 ; NOP ; NOP ; ADD x11,x10  (producer in WB: no hazard)
    set_id(5'd0, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0); wait_issue(nst);
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); wait_issue(nst);
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); wait_issue(nst);
    set_id(5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0); wait_issue(nst);
    check("wb_stalls", nst, 32'd0);
    check("wb_fwd1", {30'd0, fwd_rs1_sel}, 32'd0);

    // LW x12 ; ADD x13,x12 with simultaneous ex_redirect
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0); wait_issue(nst);
    set_id(5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
    ex_redirect = 1'b1;
    @(negedge clk);
    check("redir_flush",  {31'd0, flush_if},  32'd1);
    check("redir_bubble", {31'd0, bubble_ex}, 32'd1);
    check("redir_stall",  {31'd0, stall_id},  32'd0);
    @(posedge clk); #1;
    check("redir_cnt", stall_cnt, FWD ? 32'd1 : 32'd5);
    idle();
    @(posedge clk); #1;

    // JAL x1 ; ADD x2,x1
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("jal_flush", {31'd0, flush_if}, 32'd1);
    check("jal_stall", {31'd0, stall_if}, 32'd0);
    @(posedge clk); #1;
    set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0); wait_issue(nst);
    check("jal_dep_stalls", nst, FWD ? 32'd0 : 32'd2);
    check("jal_dep_fwd1", {30'd0, fwd_rs1_sel}, FWD ? 32'd1 : 32'd0);

    // LW x14 ; ADD x15,x14 then reset while stalled
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 1'b1, 1'b0); wait_issue(nst);
    set_id(5'd14, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("mid_stall_before", {31'd0, stall_id}, 32'd1);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_stall_after", {31'd0, stall_id}, 32'd0);
    check("mid_cnt", stall_cnt, 32'd0);
    @(posedge clk); #1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
